wave_nco: RTL and testbench

Parametrised numerically-controlled oscillator that generates pulse, sawtooth or triangle waves.
- Output is a signed amplitude of configurable width.
- Frequency, duty cycle and mode are double-buffered. New settings load through a strobe and take effect only at a phase wrap, so waveform periods are never truncated.
- A sync input restarts the phase.
- Used as a per-voice source feeding the mixer.

---
 rtl/wave_nco.sv | 85 ++++++++
 tb/tb_wave_nco.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/wave_nco.sv
// wave_nco: NCO producing pulse/saw/triangle waves with double-buffered settings.
// Ports: clk, rst_n (sync, active-low); ctrl_in/duty_in/mode_in with load strobe go to
// a pending set that becomes active at the next phase wrap; sync restarts the phase and
// applies pending/load values at once; busy = pending valid; wrap = carry strobe;
// value = registered signed amplitude.
module wave_nco #(
  parameter int PHASE_W = 32,
  parameter int OUT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PHASE_W-1:0]       ctrl_in,
  input  logic [PHASE_W-1:0]       duty_in,
  input  logic [1:0]               mode_in,
  input  logic                     load,
  input  logic                     sync,
  output logic                     busy,
  output logic                     wrap,
  output logic signed [OUT_W-1:0]  value
);
  logic [PHASE_W-1:0] phase, ctrl_act, duty_act, ctrl_pend, duty_pend;
  logic [1:0] mode_act, mode_pend;
  logic pend_valid;
  logic [PHASE_W:0] sum;
  logic [OUT_W-1:0] pos_a, neg_a, saw, tri_t, tri_v, next_val;
  assign busy = pend_valid;
  assign sum = {1'b0, phase} + {1'b0, ctrl_act};
  always_comb begin
    pos_a = {1'b0, {(OUT_W-1){1'b1}}};
    neg_a = ~pos_a + OUT_W'(1);
    saw = {~phase[PHASE_W-1], phase[PHASE_W-2 -: OUT_W-1]};
    // Second half of the period mirrors the first so the ramp folds back down.
    tri_t = phase[PHASE_W-1] ? ~phase[PHASE_W-2 -: OUT_W] : phase[PHASE_W-2 -: OUT_W];
    tri_v = {~tri_t[OUT_W-1], tri_t[OUT_W-2:0]};
    next_val = mode_act == 2'd0 ? ((phase < duty_act) ? pos_a : neg_a) :
               mode_act == 2'd1 ? saw :
               mode_act == 2'd2 ? tri_v : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= '0;
      ctrl_act <= '0;
      duty_act <= {1'b1, {(PHASE_W-1){1'b0}}};
      mode_act <= 2'd3;
      ctrl_pend <= '0;
      duty_pend <= '0;
      mode_pend <= 2'd3;
      pend_valid <= 1'b0;
      wrap <= 1'b0;
      value <= '0;
    end else begin
      value <= next_val;
      if (sync) begin
        phase <= '0;
        wrap <= 1'b0;
        pend_valid <= 1'b0;
        if (load) begin
          ctrl_act <= ctrl_in;
          duty_act <= duty_in;
          mode_act <= mode_in;
        end else if (pend_valid) begin
          ctrl_act <= ctrl_pend;
          duty_act <= duty_pend;
          mode_act <= mode_pend;
        end
      end else begin
        phase <= sum[PHASE_W-1:0];
        wrap <= sum[PHASE_W];
        if (sum[PHASE_W] && pend_valid) begin
          ctrl_act <= ctrl_pend;
          duty_act <= duty_pend;
          mode_act <= mode_pend;
          pend_valid <= 1'b0;
        end
        // A load on the apply edge refills pending after the old values moved to active.
        if (load) begin
          ctrl_pend <= ctrl_in;
          duty_pend <= duty_in;
          mode_pend <= mode_in;
          pend_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_wave_nco.sv
// tb_wave_nco: randomized and directed self-checking bench for wave_nco against an arithmetic model.
module tb_wave_nco;
  localparam longint FULL = 64'd4294967296;
  localparam longint HALF = 64'd2147483648;
  logic clk = 0, rst_n = 0, load = 0, sync = 0;
  logic [31:0] ctrl_in = 0, duty_in = 0;
  logic [1:0] mode_in = 0;
  logic busy, wrap;
  logic signed [7:0] value;
  int tests = 0, fails = 0;
  longint m_phase, m_ctrl, m_duty, p_ctrl, p_duty;
  int m_mode, p_mode;
  bit m_pv, m_wrap;
  logic [7:0] m_val;

  wave_nco #(.PHASE_W(32), .OUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .duty_in(duty_in), .mode_in(mode_in),
    .load(load), .sync(sync), .busy(busy), .wrap(wrap), .value(value)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_val(longint p, longint d, int m);
    longint t;
    case (m)
      0: return (p < d) ? 8'(127) : 8'(-127);
      1: return 8'((p >> 24) - 128);
      2: begin
        t = (p % HALF) >> 23;
        if (p >= HALF) t = 255 - t;
        return 8'(t - 128);
      end
      default: return 8'd0;
    endcase
  endfunction

  task automatic tick();
    longint s;
    @(posedge clk);
    if (!rst_n) begin
      m_phase = 0; m_ctrl = 0; m_duty = HALF; m_mode = 3;
      m_pv = 0; m_wrap = 0; m_val = 0;
    end else begin
      m_val = ref_val(m_phase, m_duty, m_mode);
      if (sync) begin
        m_phase = 0; m_wrap = 0;
        if (load) begin m_ctrl = ctrl_in; m_duty = duty_in; m_mode = mode_in; end
        else if (m_pv) begin m_ctrl = p_ctrl; m_duty = p_duty; m_mode = p_mode; end
        m_pv = 0;
      end else begin
        s = m_phase + m_ctrl;
        m_wrap = s >= FULL;
        m_phase = s % FULL;
        if (m_wrap && m_pv) begin m_ctrl = p_ctrl; m_duty = p_duty; m_mode = p_mode; m_pv = 0; end
        if (load) begin p_ctrl = ctrl_in; p_duty = duty_in; p_mode = mode_in; m_pv = 1; end
      end
    end
    #1;
  endtask

  task automatic drive(bit l, bit s, logic [31:0] c, logic [31:0] d, logic [1:0] m);
    load = l; sync = s; ctrl_in = c; duty_in = d; mode_in = m;
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(); tick();
    tests++;
    if (value !== 8'd0 || busy !== 1'b0 || wrap !== 1'b0) begin
      fails++; $display("FAIL reset: value=%h busy=%b wrap=%b, want 00/0/0", value, busy, wrap);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_pattern(logic [1:0] mode, logic [7:0] p0, logic [7:0] p1, logic [7:0] p2, logic [7:0] p3);
    logic [7:0] pat [4];
    pat = '{p0, p1, p2, p3};
    drive(1, 1, 32'h4000_0000, 32'h8000_0000, mode);
    tick();
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      tick();
      tests++;
      if (value !== pat[k % 4] || value !== m_val || wrap !== (k % 4 == 3) || busy !== 1'b0) begin
        fails++;
        $display("FAIL pattern m%0d k%0d: value=%h wrap=%b busy=%b, want %h/%b/0", mode, k, value, wrap, busy, pat[k % 4], k % 4 == 3);
      end
    end
  endtask

  task automatic test_midperiod_load();
    drive(1, 1, 32'h4000_0000, 32'h8000_0000, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 32'h4000_0000, 32'h4000_0000, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL busy_after_load: busy=%b want 1", busy); end
    for (int k = 0; k < 12; k++) begin
      tick();
      tests++;
      if (value !== m_val || busy !== m_pv || wrap !== m_wrap) begin
        fails++; $display("FAIL midload k%0d: value=%h busy=%b wrap=%b, want %h/%b/%b", k, value, busy, wrap, m_val, m_pv, m_wrap);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 32'h4000_0000, 32'h2000_0000, 0);
    tick();
    drive(1, 0, 32'h4000_0000, 32'h2000_0000, 3);
    tick();
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      tests++;
      if (value !== m_val || busy !== m_pv || wrap !== m_wrap) begin
        fails++; $display("FAIL b2b k%0d: value=%h busy=%b wrap=%b, want %h/%b/%b", k, value, busy, wrap, m_val, m_pv, m_wrap);
      end
    end
    tests++;
    if (value !== 8'd0) begin fails++; $display("FAIL b2b_mute: value=%h want 00", value); end
  endtask

  task automatic test_sync_load();
    drive(1, 0, 32'h1000_0000, 32'h1000_0000, 2);
    tick();
    drive(1, 1, 32'h8000_0000, 32'h8000_0000, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    tests++;
    if (busy !== 1'b0 || wrap !== 1'b0) begin fails++; $display("FAIL sync_load: busy=%b wrap=%b want 0/0", busy, wrap); end
    for (int k = 0; k < 8; k++) begin
      tick();
      tests++;
      if (wrap !== (k % 2 == 1) || value !== m_val) begin
        fails++; $display("FAIL sync_wrap k%0d: wrap=%b value=%h, want %b/%h", k, wrap, value, k % 2 == 1, m_val);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 32'h4000_0000, 32'h8000_0000, 1);
    rst_n = 0;
    tick();
    tests++;
    if (value !== 8'd0 || busy !== 1'b0 || wrap !== 1'b0) begin
      fails++; $display("FAIL reset_mid: value=%h busy=%b wrap=%b, want 00/0/0", value, busy, wrap);
    end
    rst_n = 1;
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      tests++;
      if (value !== 8'd0 || wrap !== 1'b0) begin fails++; $display("FAIL post_reset k%0d: value=%h wrap=%b want 00/0", k, value, wrap); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
            {$urandom_range(0, 3) == 0 ? 4'h0 : 4'($urandom), 28'($urandom)}, $urandom, 2'($urandom));
      tick();
      tests++;
      if (value !== m_val || busy !== m_pv || wrap !== m_wrap) begin
        fails++; $display("FAIL random k%0d: value=%h busy=%b wrap=%b, want %h/%b/%b", k, value, busy, wrap, m_val, m_pv, m_wrap);
      end
    end
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_pattern(0, 8'h7F, 8'h7F, 8'h81, 8'h81);
    test_pattern(1, 8'h80, 8'hC0, 8'h00, 8'h40);
    test_pattern(2, 8'h80, 8'h00, 8'h7F, 8'hFF);
    test_midperiod_load();
    test_back_to_back();
    test_sync_load();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
